sprite_plotter: RTL and testbench

- Downstream consumer of the 5x5 animated pellet/sprite bitmap generator.
- On a start request, snapshots a 25-bit shape, an origin and two colours, then walks the 25 pixels in row-major order.
- Emits one pixel write per cycle as (x, y, colour, plot) to the VGA framebuffer adapter.
- Supports a stall input so the framebuffer arbiter can back-pressure the walk.

---
 rtl/sprite_plotter.sv | 151 +++++++++++++++
 tb/tb_sprite_plotter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// sprite_plotter: snapshots a 5x5 sprite and walks it row-major, one framebuffer write per cycle.
// First pixel one cycle after start; stall freezes the walk and masks plot. Option: SPRITE_TRANSPARENT_EN.
module sprite_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [24:0]         shape,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_n;
  logic [24:0]           shape_q, shape_n;
  logic [X_W-1:0]        ox_q, ox_n;
  logic [Y_W-1:0]        oy_q, oy_n;
  logic [COLOUR_W-1:0]   fg_q, fg_n, bg_q, bg_n;
  logic [2:0]            row_q, row_n, col_q, col_n;
  logic [4:0]            pix_q, pix_n;
  logic [X_W-1:0]        x_n;
  logic [Y_W-1:0]        y_n;
  logic [COLOUR_W-1:0]   colour_n;
  logic                  plot_q, plot_n, busy_n, done_n;
  logic                  present, pix_bit;

  always_comb begin
    state_n  = state;
    shape_n  = shape_q;
    ox_n     = ox_q;
    oy_n     = oy_q;
    fg_n     = fg_q;
    bg_n     = bg_q;
    row_n    = row_q;
    col_n    = col_q;
    pix_n    = pix_q;
    x_n      = plot_x;
    y_n      = plot_y;
    colour_n = plot_colour;
    plot_n   = plot_q;
    busy_n   = busy;
    done_n   = 1'b0;
    present  = 1'b0;
    pix_bit  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shape_n = shape;
          ox_n    = origin_x;
          oy_n    = origin_y;
          fg_n    = fg_colour;
          bg_n    = bg_colour;
          row_n   = 3'd0;
          col_n   = 3'd0;
          pix_n   = 5'd0;
          busy_n  = 1'b1;
          present = 1'b1;
          state_n = DRAW;
        end
      end
      DRAW: begin
        if (!stall) begin
          if (pix_q == 5'd24) begin
            state_n = DONE;
            busy_n  = 1'b0;
            plot_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            present = 1'b1;
            pix_n   = pix_q + 5'd1;
            if (col_q == 3'd4) begin
              col_n = 3'd0;
              row_n = row_q + 3'd1;
            end else begin
              col_n = col_q + 3'd1;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Register the pixel that will be on the outputs next cycle, from the post-update snapshot.
    if (present) begin
      pix_bit  = shape_n[5'd24 - pix_n];
      x_n      = ox_n + X_W'(col_n);
      y_n      = oy_n + Y_W'(row_n);
      colour_n = pix_bit ? fg_n : bg_n;
`ifdef SPRITE_TRANSPARENT_EN
      plot_n   = pix_bit;
`else
      plot_n   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shape_q     <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pix_q       <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shape_q     <= shape_n;
      ox_q        <= ox_n;
      oy_q        <= oy_n;
      fg_q        <= fg_n;
      bg_q        <= bg_n;
      row_q       <= row_n;
      col_q       <= col_n;
      pix_q       <= pix_n;
      plot_x      <= x_n;
      plot_y      <= y_n;
      plot_colour <= colour_n;
      plot_q      <= plot_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // A stalled cycle keeps the pixel on the bus but must not write it.
  assign plot = plot_q & ~stall;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: table of draws plus reset, restart and abort sequences.
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [24:0] shape = '0;
  logic [7:0]  origin_x = '0;
  logic [6:0]  origin_y = '0;
  logic [2:0]  fg_colour = '0;
  logic [2:0]  bg_colour = '0;
  logic        busy, done, plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;

  sprite_plotter #(.X_W(8), .Y_W(7), .COLOUR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .shape(shape),
    .origin_x(origin_x), .origin_y(origin_y), .fg_colour(fg_colour),
    .bg_colour(bg_colour), .stall(stall), .busy(busy), .done(done),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] shape;
    logic [7:0]  ox;
    logic [6:0]  oy;
    logic [2:0]  fg;
    logic [2:0]  bg;
    int          stall_at;
    int          stall_len;
    bit          toggle;
    int          start_mid;
    int          exp_fg;
    int          exp_done;
    logic [7:0]  exp_last_x;
    logic [6:0]  exp_last_y;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_draw(input int i);
    vec_t       v;
    int         k, cyc, fg_cnt, plot_cnt, done_cyc, stall_left, row, col;
    bit         mid_done, stalled, bitv;
    logic       exp_plot;
    logic [7:0] ex, last_x;
    logic [6:0] ey, last_y;
    logic [2:0] ec;
    logic [7:0] fgx[$];
    logic [6:0] fgy[$];
    logic [7:0] exp_fx[7] = '{8'd12, 8'd13, 8'd11, 8'd12, 8'd13, 8'd11, 8'd12};
    logic [6:0] exp_fy[7] = '{7'd21, 7'd21, 7'd22, 7'd22, 7'd22, 7'd23, 7'd23};
    v = vecs[i];
    k = 0; cyc = 0; fg_cnt = 0; plot_cnt = 0; done_cyc = -1;
    stall_left = v.stall_len; mid_done = 0;
    last_x = '0; last_y = '0;

    @(negedge clk);
    shape = v.shape; origin_x = v.ox; origin_y = v.oy;
    fg_colour = v.fg; bg_colour = v.bg; stall = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (v.toggle) shape = ~shape;
      if (v.start_mid >= 0) begin
        if (k == v.start_mid && !mid_done) begin start = 1'b1; mid_done = 1; end
        else start = 1'b0;
      end
      stalled = (k == v.stall_at) && (stall_left > 0);
      if (stalled) stall_left--;
      stall = stalled;
      #1;
      if (done) begin
        done_cyc = cyc;
        cmp($sformatf("v%0d_done_quiet", i), {busy, plot}, 2'b00);
        break;
      end
      if (busy) begin
        if (k >= 25) begin
          cmp($sformatf("v%0d_overrun", i), k, 24);
          break;
        end
        row  = k / 5;
        col  = k % 5;
        bitv = v.shape[24 - k];
        ex   = v.ox + 8'(col);
        ey   = v.oy + 7'(row);
        ec   = bitv ? v.fg : v.bg;
`ifdef SPRITE_TRANSPARENT_EN
        exp_plot = bitv & !stalled;
`else
        exp_plot = !stalled;
`endif
        cmp($sformatf("v%0d_pixel%0d", i, k), {plot_x, plot_y, plot_colour, plot},
            {ex, ey, ec, exp_plot});
        if (!stalled) begin
          k++;
          if (plot) plot_cnt++;
          if (plot_colour == v.fg) begin
            fg_cnt++;
            fgx.push_back(plot_x);
            fgy.push_back(plot_y);
          end
          last_x = plot_x;
          last_y = plot_y;
        end
      end
    end
    stall = 1'b0;
    start = 1'b0;

    cmp($sformatf("v%0d_done_cycle", i), done_cyc, v.exp_done);
    cmp($sformatf("v%0d_pixel_count", i), k, 25);
    cmp($sformatf("v%0d_fg_count", i), fg_cnt, v.exp_fg);
`ifdef SPRITE_TRANSPARENT_EN
    cmp($sformatf("v%0d_plot_count", i), plot_cnt, v.exp_fg);
`else
    cmp($sformatf("v%0d_plot_count", i), plot_cnt, 25);
`endif
    cmp($sformatf("v%0d_last_xy", i), {last_x, last_y}, {v.exp_last_x, v.exp_last_y});
    if (i == 0) begin
      for (int j = 0; j < 7; j++) begin
        if (j < fgx.size())
          cmp($sformatf("frame0_fg_xy%0d", j), {fgx[j], fgy[j]}, {exp_fx[j], exp_fy[j]});
        else
          cmp($sformatf("frame0_fg_xy%0d_missing", j), j, fgx.size());
      end
    end
  endtask

  initial begin
    int bad, n, got;
    //            shape                        ox      oy     fg      bg      stall  len tog mid fg done lastx   lasty
    vecs[0] = '{25'b0000000110011100110000000, 8'd10,  7'd20,  3'b110, 3'b000, -1, 0, 0, -1, 7,  26, 8'd14,  7'd24};
    vecs[1] = '{25'b0000000110011100110000000, 8'd100, 7'd50,  3'b010, 3'b001, -1, 0, 1, -1, 7,  26, 8'd104, 7'd54};
    vecs[2] = '{25'b0000000110011100110000000, 8'd10,  7'd20,  3'b110, 3'b000,  7, 3, 0, -1, 7,  29, 8'd14,  7'd24};
    vecs[3] = '{25'h1555555,                   8'd254, 7'd126, 3'b011, 3'b100, -1, 0, 0, 10, 13, 26, 8'd2,   7'd2};
    vecs[4] = '{25'h0000000,                   8'd0,   7'd0,   3'b111, 3'b101, -1, 0, 0, -1, 0,  26, 8'd4,   7'd4};

    // Reset asserted from time zero; check mid-cycle, then release.
    #7;
    cmp("reset_state", {busy, done, plot, plot_x, plot_y, plot_colour}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    #1 cmp("idle_state", {busy, done, plot, plot_x, plot_y}, '0);

    for (int i = 0; i < 5; i++) begin
      check_draw(i);
      // A single done, no queued start, and stall in IDLE is harmless.
      bad = 0;
      stall = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1 if (done || busy || plot) bad++;
      end
      stall = 1'b0;
      cmp($sformatf("v%0d_post_idle", i), bad, 0);
    end

    // Start held through the DONE cycle: ignored there, taken in the following IDLE cycle.
    check_draw(0);
    start = 1'b1;
    @(negedge clk);
    #1 cmp("done_start_ignored", {busy, done}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    #1 cmp("restart_period", {busy, plot, plot_x, plot_y}, {1'b1, 1'b1, 8'd10, 7'd20});
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      @(negedge clk);
      #1 if (done) got = 1;
    end
    cmp("restart_done", got, 1);
    repeat (2) @(negedge clk);

    // Abort mid-draw at pixel 12 (row2 col2) with an asynchronous reset.
    @(negedge clk);
    shape = vecs[0].shape; origin_x = 8'd10; origin_y = 7'd20;
    fg_colour = 3'b110; bg_colour = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      @(negedge clk);
      #1 if (busy) begin
        if (n == 12) got = 1;
        else n++;
      end
    end
    cmp("abort_reach12", {got[0], plot_x, plot_y}, {1'b1, 8'd12, 7'd22});
    #2 reset_n = 1'b0;
    #1 cmp("abort_zero", {busy, done, plot, plot_x, plot_y, plot_colour}, '0);
    @(negedge clk) reset_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      #1 if (done || busy) bad++;
    end
    cmp("abort_no_done", bad, 0);
    check_draw(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
